// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: instruction queue between IF and ID.
// Circular buffer of {inst, pc, compressed, pred_dest} with valid/ready on both
// sides and a single-cycle synchronous flush for mispredict correction.
// Optional build macro RISCV_FETCH_QUEUE_BYPASS_EN enables a combinational
// fall-through from push_* to pop_* when the queue is empty.
module riscv_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AF_LVL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [31:0]              push_inst,
    input  logic [XLEN-1:0]          push_pc,
    input  logic                     push_compressed,
    input  logic [XLEN-1:0]          push_pred_dest,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [31:0]              pop_inst,
    output logic [XLEN-1:0]          pop_pc,
    output logic                     pop_compressed,
    output logic [XLEN-1:0]          pop_pred_dest,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    // Entry storage (not reset)
    logic [31:0]      ent_inst_q [DEPTH];
    logic [XLEN-1:0]  ent_pc_q   [DEPTH];
    logic             ent_comp_q [DEPTH];
    logic [XLEN-1:0]  ent_pd_q   [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic             empty;
    logic             bypass;
    logic             push_fire;
    logic             pop_fire;
    logic             wr_en;
    logic             rd_adv;
    logic [CW-1:0]    free_cnt;

    // Handshake decode and pop-side output mux
    always_comb begin
        empty      = (count_q == '0);
        push_ready = (count_q != DEPTH_C);
`ifdef RISCV_FETCH_QUEUE_BYPASS_EN
        bypass     = empty & push_valid & ~flush;
`else
        bypass     = 1'b0;
`endif
        pop_valid  = ~empty | bypass;
        push_fire  = push_valid & push_ready;
        pop_fire   = pop_valid & pop_ready;

        // A fall-through that is consumed in the same cycle never touches storage
        wr_en      = push_fire & ~flush & ~(bypass & pop_ready);
        rd_adv     = pop_fire & ~flush & ~bypass;

        if (bypass) begin
            pop_inst       = push_inst;
            pop_pc         = push_pc;
            pop_compressed = push_compressed;
            pop_pred_dest  = push_pred_dest;
        end else if (empty) begin
            pop_inst       = NOP;
            pop_pc         = '0;
            pop_compressed = 1'b0;
            pop_pred_dest  = '0;
        end else begin
            pop_inst       = ent_inst_q[rd_ptr_q];
            pop_pc         = ent_pc_q[rd_ptr_q];
            pop_compressed = ent_comp_q[rd_ptr_q];
            pop_pred_dest  = ent_pd_q[rd_ptr_q];
        end

        free_cnt    = DEPTH_C - count_q;
        almost_full = (free_cnt <= AF_C);
        count       = count_q;
    end

    // Next-state for pointers and occupancy; flush overrides everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_adv)
                rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_inst_q[wr_ptr_q] <= push_inst;
            ent_pc_q[wr_ptr_q]   <= push_pc;
            ent_comp_q[wr_ptr_q] <= push_compressed;
            ent_pd_q[wr_ptr_q]   <= push_pred_dest;
        end
    end

endmodule
